// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//   Arbitrates the shared register read bus and the shared register write bus
//   among NUM_REQ bus masters (0 Firewire, 1 Ethernet, 2 PS EMIO). Each bus
//   has its own round-robin arbiter. The granted master's address and write
//   controls are muxed onto the register file. reg_rvalid is raised once the
//   granted read address has been stable for RD_LATENCY cycles.
//
// Ports
//   sysclk, reset          system clock, synchronous active-low reset
//   req_read_bus           per-master read bus request
//   grant_read_bus         one-hot read grant (registered)
//   raddr_all              per-master read address, master i at [16i+15:16i]
//   reg_raddr              read address of the granted master, 0 if none
//   reg_rvalid             reg_rdata valid for reg_raddr (registered)
//   req_write_bus          per-master write bus request
//   grant_write_bus        one-hot write grant (registered)
//   waddr_all, wdata_all   per-master write address / data
//   wen_all, blk_wen_all,
//   blk_wstart_all         per-master write strobes
//   reg_waddr, reg_wdata,
//   reg_wen, blk_wen,
//   blk_wstart             write controls of the granted master, 0 if none
// ---------------------------------------------------------------------------

// Single-bus round-robin arbiter: IDLE -> GRANTED -> GAP -> IDLE.
module reg_bus_arb_fsm #(
    parameter int NUM_REQ = 3
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_GAP     = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   win_next_ptr;
    logic               holder_req;

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NUM_REQ;
    endfunction

    // Round-robin search starting at ptr_q. Scanning from the farthest offset
    // back to the nearest lets the nearest requester overwrite the others.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        win_onehot   = '0;
        win_next_ptr = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr_q), k)]) begin
                win_onehot                             = '0;
                win_onehot[wrap_idx(int'(ptr_q), k)]   = 1'b1;
                win_next_ptr = PTR_W'(wrap_idx(wrap_idx(int'(ptr_q), k), 1));
            end
        end
    end

    // Only the current holder's request keeps the grant; others never preempt.
    assign holder_req = |(grant_q & req);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|req) state_d = ST_GRANTED;
            ST_GRANTED: if (!holder_req) state_d = ST_GAP;
            ST_GAP:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Grant and pointer logic
    always_comb begin
        grant_d = '0;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = win_onehot;
                    ptr_d   = win_next_ptr;
                end
            end
            ST_GRANTED: if (holder_req) grant_d = grant_q;
            default:    grant_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
endmodule

module reg_bus_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int RD_LATENCY = 2
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_read_bus,
    output logic [NUM_REQ-1:0]    grant_read_bus,
    input  logic [16*NUM_REQ-1:0] raddr_all,
    output logic [15:0]           reg_raddr,
    output logic                  reg_rvalid,
    input  logic [NUM_REQ-1:0]    req_write_bus,
    output logic [NUM_REQ-1:0]    grant_write_bus,
    input  logic [16*NUM_REQ-1:0] waddr_all,
    input  logic [32*NUM_REQ-1:0] wdata_all,
    input  logic [NUM_REQ-1:0]    wen_all,
    input  logic [NUM_REQ-1:0]    blk_wen_all,
    input  logic [NUM_REQ-1:0]    blk_wstart_all,
    output logic [15:0]           reg_waddr,
    output logic [31:0]           reg_wdata,
    output logic                  reg_wen,
    output logic                  blk_wen,
    output logic                  blk_wstart
);
    localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);

    logic [16*NUM_REQ-1:0] raddr_prev_q;
    logic [15:0]           raddr_prev;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rd_hold, rd_stable, rd_keep;

    reg_bus_arb_fsm #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .sysclk (sysclk),
        .reset  (reset),
        .req    (req_read_bus),
        .grant  (grant_read_bus)
    );

    reg_bus_arb_fsm #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .sysclk (sysclk),
        .reset  (reset),
        .req    (req_write_bus),
        .grant  (grant_write_bus)
    );

    // Grants are one-hot or zero, so OR-ing the gated lanes is a clean mux
    // that yields 0 when nobody is granted.
    always_comb begin
        reg_raddr  = '0;
        raddr_prev = '0;
        reg_waddr  = '0;
        reg_wdata  = '0;
        reg_wen    = 1'b0;
        blk_wen    = 1'b0;
        blk_wstart = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_read_bus[i]) begin
                reg_raddr  |= raddr_all[16*i +: 16];
                raddr_prev |= raddr_prev_q[16*i +: 16];
            end
            if (grant_write_bus[i]) begin
                reg_waddr  |= waddr_all[16*i +: 16];
                reg_wdata  |= wdata_all[32*i +: 32];
                reg_wen    |= wen_all[i];
                blk_wen    |= blk_wen_all[i];
                blk_wstart |= blk_wstart_all[i];
            end
        end
    end

    // Settle counter: restarts whenever the grant is absent or the granted
    // master moves its address. rd_keep tells whether the grant survives this
    // edge, so reg_rvalid drops on the same edge the grant does.
    always_comb begin
        rd_hold   = |grant_read_bus;
        rd_stable = (reg_raddr == raddr_prev);
        rd_keep   = |(grant_read_bus & req_read_bus);
        cnt_d     = '0;
        rvalid_d  = 1'b0;
        if (rd_hold && rd_stable) begin
            cnt_d    = (cnt_q == RD_LAT) ? cnt_q : cnt_q + 3'd1;
            rvalid_d = (cnt_q == RD_LAT) && rd_keep;
        end
    end

    // NOTE: the previous-address history is a pure data pipeline; it needs no
    // reset because it is only compared while a grant is held.
    always_ff @(posedge sysclk) begin
        raddr_prev_q <= raddr_all;
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign reg_rvalid = rvalid_q;
endmodule
